// File: rtl/uart_instr_loader.sv
// UART (8N1, LSB first) receiver that packs every four bytes big-endian into a
// 32-bit instruction word and streams the words into instruction memory.
module uart_instr_loader #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int ADDR_WIDTH   = 8,
  parameter int IDLE_TIMEOUT = 2000000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_rx,
  input  logic                  i_start_cpu,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [31:0]           o_wr_data,
  output logic                  o_instr_transmit_done,
  output logic [ADDR_WIDTH-1:0] o_max_addr,
  output logic                  o_frame_error
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int TMR_W = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]      HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]      BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [TMR_W-1:0]      TMR_LAST  = TMR_W'(IDLE_TIMEOUT - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic                  rx_meta_q, rx_sync_q, rx_prev_q;
  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2:0]            bit_q, bit_d;
  logic [7:0]            shift_q, shift_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [23:0]           word_q, word_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]           wr_data_q, wr_data_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] max_q, max_d;
  logic                  done_q, done_d;
  logic                  ferr_q, ferr_d;
  logic                  wrote_q, wrote_d;
  logic [TMR_W-1:0]      tmr_q, tmr_d;

  logic byte_ok, stop_bad, start_seen;

  // RX framing FSM; byte_ok/stop_bad fire in the cycle the stop bit is sampled.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    byte_ok    = 1'b0;
    stop_bad   = 1'b0;
    start_seen = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_sync_q && !i_start_cpu && !done_q) begin
          state_d    = S_START;
          bit_d      = '0;
          start_seen = 1'b1;
        end
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = rx_sync_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d    = '0;
          state_d  = S_IDLE;
          byte_ok  = rx_sync_q && !done_q;
          stop_bad = !rx_sync_q && !done_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Word assembly, memory write, end-of-transfer detection.
  always_comb begin
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    ptr_d      = ptr_q;
    max_d      = max_q;
    done_d     = done_q;
    ferr_d     = ferr_q;
    wrote_d    = wrote_q;
    tmr_d      = tmr_q;

    if (byte_ok) begin
      if (byte_idx_q == 2'd3) begin
        wr_en_d    = 1'b1;
        wr_data_d  = {word_q, shift_q};
        wr_addr_d  = ptr_q;
        max_d      = ptr_q;
        wrote_d    = 1'b1;
        byte_idx_d = '0;
        if (ptr_q != ADDR_LAST) ptr_d = ptr_q + ADDR_WIDTH'(1);
      end else begin
        word_d     = {word_q[15:0], shift_q};
        byte_idx_d = byte_idx_q + 2'd1;
      end
    end

    if (stop_bad) begin
      ferr_d     = 1'b1;
      byte_idx_d = '0;
    end

    // Memory is full once the top address has been written.
    if (wr_en_q && wr_addr_q == ADDR_LAST) done_d = 1'b1;

    if (start_seen) begin
      tmr_d = '0;
    end else if (state_q == S_IDLE && wrote_q && !done_q) begin
      if (tmr_q == TMR_LAST) begin
        done_d     = 1'b1;
        byte_idx_d = '0;
        tmr_d      = '0;
      end else begin
        tmr_d = tmr_q + TMR_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      ptr_q      <= '0;
      max_q      <= '0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
      wrote_q    <= 1'b0;
      tmr_q      <= '0;
    end else begin
      rx_meta_q  <= i_rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      ptr_q      <= ptr_d;
      max_q      <= max_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
      wrote_q    <= wrote_d;
      tmr_q      <= tmr_d;
    end
  end

  assign o_wr_en               = wr_en_q;
  assign o_wr_addr             = wr_addr_q;
  assign o_wr_data             = wr_data_q;
  assign o_instr_transmit_done = done_q;
  assign o_max_addr            = max_q;
  assign o_frame_error         = ferr_q;

endmodule

// File: tb/tb_uart_instr_loader.sv
// Bench for uart_instr_loader: byte-level UART driver, write scoreboard,
// table of word vectors plus hand-written corner-case sequences.
module tb_uart_instr_loader;

  localparam int CPB  = 16;
  localparam int AW   = 6;    // 64-word memory keeps the fill test short
  localparam int TMO  = 500;
  localparam int GAP  = 4;
  localparam logic [AW-1:0] ALAST = '1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx = 1'b1;
  logic          start_cpu = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          done;
  logic [AW-1:0] max_addr;
  logic          ferr;

  uart_instr_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW), .IDLE_TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx), .i_start_cpu(start_cpu),
    .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .o_instr_transmit_done(done), .o_max_addr(max_addr), .o_frame_error(ferr)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [AW-1:0] addr; logic [31:0] data; } exp_t;
  typedef struct { logic [7:0] b0, b1, b2, b3; logic [31:0] data; } vec_t;

  exp_t        exp_q[$];
  vec_t        vecs[6];
  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned last_wr_cyc = 0;
  bit          full_pend = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0; tick(CPB);
    for (int i = 0; i < 8; i++) begin rx = b[i]; tick(CPB); end
    rx = stop; tick(CPB);
    rx = 1'b1; tick(GAP);
  endtask

  task automatic send_word(input vec_t v, input logic [AW-1:0] a, input bit expect_wr);
    exp_t e;
    if (expect_wr) begin
      e.addr = a; e.data = v.data;
      exp_q.push_back(e);
    end
    send_byte(v.b0, 1'b1); send_byte(v.b1, 1'b1);
    send_byte(v.b2, 1'b1); send_byte(v.b3, 1'b1);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_done(input string name, input int bound);
    for (int i = 0; i < bound && !done; i++) @(negedge clk);
    chk(name, 32'(done), 32'd1);
  endtask

  task automatic wait_until(input int unsigned c);
    for (int i = 0; i < 5000 && cyc < c; i++) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wr_en"},   32'(wr_en),    32'd0);
    chk({tag, "_wr_addr"}, 32'(wr_addr),  32'd0);
    chk({tag, "_wr_data"}, wr_data,       32'd0);
    chk({tag, "_done"},    32'(done),     32'd0);
    chk({tag, "_max"},     32'(max_addr), 32'd0);
    chk({tag, "_ferr"},    32'(ferr),     32'd0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); chk_zero(tag);
    rst_n = 1'b1; full_pend = 1'b0;
    exp_q.delete();
    tick(3);
  endtask

  initial begin
    exp_t e;
    vec_t v;

    vecs[0] = '{8'h12, 8'h34, 8'h56, 8'h78, 32'h12345678};
    vecs[1] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 32'hAABBCCDD};
    vecs[2] = '{8'h00, 8'h00, 8'h00, 8'h01, 32'h00000001};
    vecs[3] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 32'hFFFFFFFF};
    vecs[4] = '{8'h01, 8'h02, 8'h03, 8'h04, 32'h01020304};
    vecs[5] = '{8'hA5, 8'h3C, 8'h0F, 8'hF0, 32'hA53C0FF0};

    // Write monitor: every o_wr_en cycle must match the head of the scoreboard.
    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (full_pend) begin
            chk("done_after_full", 32'(done), 32'd1);
            full_pend = 1'b0;
          end
          if (wr_en) begin
            if (exp_q.size() == 0) begin
              chk("spurious_wr_en", 32'(wr_en), 32'd0);
            end else begin
              e = exp_q.pop_front();
              chk("wr_addr", 32'(wr_addr), 32'(e.addr));
              chk("wr_data", wr_data, e.data);
              chk("max_at_wr", 32'(max_addr), 32'(e.addr));
              chk("done_at_wr", 32'(done), 32'd0);
              last_wr_cyc = cyc;
              if (e.addr == ALAST) full_pend = 1'b1;
            end
          end
        end
      end
    join_none

    rst_n = 1'b0;
    tick(3);
    chk_zero("rst0");
    rst_n = 1'b1;
    tick(5);

    // single word, then idle timeout
    send_word(vecs[0], '0, 1'b1);
    wait_drain("t1_drain");
    chk("t1_max", 32'(max_addr), 32'd0);
    chk("t1_done_early", 32'(done), 32'd0);
    wait_until(last_wr_cyc + TMO - 10);
    chk("t1_done_before_tmo", 32'(done), 32'd0);
    chk("t1_hold_data", wr_data, 32'h12345678);
    chk("t1_hold_addr", 32'(wr_addr), 32'd0);
    chk("t1_wr_en_low", 32'(wr_en), 32'd0);
    wait_until(last_wr_cyc + TMO + 10);
    chk("t1_done_after_tmo", 32'(done), 32'd1);

    // three words from the table, then a partial word and timeout
    do_reset("t2_rst");
    for (int i = 1; i <= 3; i++) send_word(vecs[i], AW'(i - 1), 1'b1);
    wait_drain("t2_drain");
    chk("t2_max", 32'(max_addr), 32'd2);
    send_byte(8'hC3, 1'b1);
    send_byte(8'h3C, 1'b1);
    chk("t2_not_done_yet", 32'(done), 32'd0);
    wait_done("t2_done", TMO + 200);
    chk("t2_max_kept", 32'(max_addr), 32'd2);

    // bad stop bit drops the partial word; no timeout before any write
    do_reset("t3_rst");
    send_byte(8'hEE, 1'b1);
    send_byte(8'hEF, 1'b1);
    send_byte(8'h5A, 1'b0);
    chk("t3_ferr", 32'(ferr), 32'd1);
    tick(TMO + 200);
    chk("t3_no_tmo", 32'(done), 32'd0);
    chk("t3_no_wr_data", wr_data, 32'd0);
    send_word(vecs[4], '0, 1'b1);
    wait_drain("t3_drain");
    chk("t3_ferr_sticky", 32'(ferr), 32'd1);

    // reset mid-word, then a start-bit glitch
    do_reset("t4_rst");
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    do_reset("t4_rst_mid");
    rx = 1'b0; tick(4);
    rx = 1'b1; tick(40);
    chk("t4_glitch_ferr", 32'(ferr), 32'd0);
    send_word(vecs[5], '0, 1'b1);
    wait_drain("t4_drain");

    // fill the whole memory, then one more word is ignored
    do_reset("t5_rst");
    for (int w = 0; w <= int'(ALAST); w++) begin
      v.b0 = 8'(w); v.b1 = ~8'(w); v.b2 = 8'(w) ^ 8'h5A; v.b3 = 8'(w * 3);
      v.data = {v.b0, v.b1, v.b2, v.b3};
      send_word(v, AW'(w), 1'b1);
    end
    wait_drain("t5_drain");
    tick(2);
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_max", 32'(max_addr), 32'(ALAST));
    send_word(vecs[0], '0, 1'b0);
    tick(20);
    chk("t5_after_max", 32'(max_addr), 32'(ALAST));
    chk("t5_after_data", wr_data, {8'(ALAST), ~8'(ALAST), 8'(ALAST) ^ 8'h5A, 8'(int'(ALAST) * 3)});

    // reset after done; start switch raised mid-byte, then held
    do_reset("t6_rst");
    send_word(vecs[1], '0, 1'b1);
    wait_drain("t6_drain0");
    e.addr = AW'(1); e.data = vecs[2].data;
    exp_q.push_back(e);
    send_byte(vecs[2].b0, 1'b1);
    send_byte(vecs[2].b1, 1'b1);
    send_byte(vecs[2].b2, 1'b1);
    fork
      send_byte(vecs[2].b3, 1'b1);
      begin tick(CPB * 4); start_cpu = 1'b1; end
    join
    wait_drain("t6_drain1");
    send_word(vecs[3], AW'(2), 1'b0);
    tick(20);
    chk("t6_blocked_addr", 32'(wr_addr), 32'd1);
    chk("t6_blocked_data", wr_data, 32'h00000001);
    chk("t6_ferr", 32'(ferr), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_instr_loader.md
Name: uart_instr_loader

Overview:
Upstream stage of the CPU core. It deserialises the board UART line (8N1, LSB first) and assembles every 4 received bytes into one 32-bit instruction word. Each word is written into instruction memory at incrementing addresses. It reports the transfer-done and maximum-address status consumed by the CPU, the LED display and the seven-segment display.

Parameters:
CLKS_PER_BIT, 10417, i_clk cycles per UART bit (100 MHz / 9600 baud).
ADDR_WIDTH, 8, instruction memory address width.
IDLE_TIMEOUT, 2000000, idle-line cycles after the last word that end the transfer.

Ports:
i_clk  in  1  system clock, all logic on rising edge.
i_rst_n  in  1  synchronous active-low reset.
i_rx  in  1  raw UART RX pin, asynchronous.
i_start_cpu  in  1  debounced start switch; while 1, reception is ignored.
o_wr_en  out  1  one-cycle memory write strobe.
o_wr_addr  out  ADDR_WIDTH  write address.
o_wr_data  out  32  instruction word.
o_instr_transmit_done  out  1  sticky transfer-complete flag.
o_max_addr  out  ADDR_WIDTH  address of the last word written.
o_frame_error  out  1  sticky, a stop bit was sampled low.

Behaviour:
- Reset (i_rst_n=0 at a clock edge) clears all outputs, counters and FSMs to 0. RX FSM goes to IDLE. Synchroniser flops are set to 1 (line idle).
- i_rx passes through a 2-FF synchroniser. All references to rx below mean the synchronised value.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: falling edge of rx with i_start_cpu=0 and done=0 -> START, bit counter cleared.
  - START: at cycle CLKS_PER_BIT/2, rx=0 -> DATA. rx=1 -> IDLE (glitch rejected, no byte).
  - DATA: sample every CLKS_PER_BIT cycles. 8 bits, LSB first, shifted into a byte register. -> STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - rx=1: byte valid, one-cycle internal pulse, -> IDLE.
    - rx=0: o_frame_error<=1, byte discarded, the partially assembled word is discarded (byte index<=0), -> IDLE.
- Word assembly is big-endian: the first byte of a group lands in [31:24], the fourth in [7:0].
- On the 4th valid byte, the cycle after that byte's pulse:
  - o_wr_en=1 for exactly 1 cycle.
  - o_wr_data = assembled word.
  - o_wr_addr = write pointer.
  - o_max_addr <= write pointer.
  - Write pointer then increments.
- o_wr_addr and o_wr_data hold their values until the next write.
- Idle timer:
  - Counts while the RX FSM is in IDLE, at least one word has been written, and done=0.
  - Cleared by any start bit.
  - On reaching IDLE_TIMEOUT: o_instr_transmit_done<=1, and any partial word (1-3 bytes) is discarded.
- Full condition: a write to address 2^ADDR_WIDTH-1 sets o_instr_transmit_done=1 on the next cycle. The pointer does not wrap.
- Once o_instr_transmit_done=1, it stays set until reset. All further UART traffic is ignored, with no writes and no error updates.
- i_start_cpu rising mid-byte: the current byte completes and is accepted. No new start bit is accepted while i_start_cpu=1.
- Before any word has been written, no timeout occurs and done stays 0 indefinitely.
- Reset mid-byte or mid-word: everything is discarded. The next start bit begins a fresh word at address 0.
- Latency: last stop-bit sample to o_wr_en is 1 cycle.

Test Plan (CLKS_PER_BIT=16, IDLE_TIMEOUT=500):
1. Send bytes 0x12,0x34,0x56,0x78 -> single o_wr_en pulse with o_wr_addr=0x00, o_wr_data=0x12345678, o_max_addr=0x00, done=0. After 500 idle cycles, done=1.
2. Send 3 words (0xAABBCCDD, 0x00000001, 0xFFFFFFFF) -> writes at addresses 0,1,2 with matching data, o_max_addr=0x02. Send 2 extra bytes, then idle -> no 4th write, done=1.
3. Send byte 0x5A with stop bit forced 0 -> o_frame_error=1, no write. Then send 4 good bytes 0x01..0x04 -> write 0x01020304 at address 0.
4. Hold rx low for 4 cycles only (glitch) -> FSM returns to IDLE, no byte is counted, and the next 4 bytes form word 0 correctly.
5. Send 256 words -> last write at address 0xFF, done=1 the next cycle. A 257th word produces no o_wr_en.
6. After done=1, pull i_rst_n=0 for 1 cycle -> all outputs read 0. Send 4 bytes -> write at address 0. Separately, with i_start_cpu=1, send 4 bytes -> no o_wr_en.
